// File: rtl/mcp_tx_ctrl.sv
// mcp_tx_ctrl: TX-domain front end of a toggle-based multi-cycle-path CDC link.
//   Takes one producer word at a time, holds it on data_out, flips req_toggle,
//   then blocks new words until the RX ack toggle comes back (level-matched).
// Ports:
//   clk_tx, rst_n (async, active-low)
//   in_valid/in_ready/in_data : producer handshake (in_ready registered)
//   ack_toggle                : RX acknowledge, asynchronous to clk_tx
//   clr_err                   : one-cycle clear of the sticky error flags
//   req_toggle, data_out      : registered MCP request and held data
//   busy, timeout_err, proto_err, xfer_count : status
module mcp_tx_ctrl #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_tx,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ack_toggle,
  input  logic              clr_err,
  output logic              req_toggle,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              timeout_err,
  output logic              proto_err,
  output logic [15:0]       xfer_count
);

  localparam int TCW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TMO_MAX = TCW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_sync;
  logic                   ack_prev;
  logic [TCW-1:0]         tcnt;

  logic accept;
  logic done;
  logic waiting;
  logic tcnt_sat;
  logic tmo_hit;
  logic proto_hit;

  // Plain flop chain: the first stage samples ack_toggle directly.
  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_toggle};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    waiting   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Level compare: the RX side has caught up once its ack parity
        // equals our request parity.
        if (ack_sync == req_toggle) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          waiting = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign tcnt_sat = (tcnt == TMO_MAX);
  // Flag on the edge where the counter reaches the limit, and keep
  // asserting while saturated so a clear during a stuck wait cannot stick.
  assign tmo_hit  = (TIMEOUT_CYC != 0) && waiting &&
                    (tcnt_sat || ((tcnt + TCW'(1)) == TMO_MAX));
  // Any ack movement outside WAIT_ACK means the RX side toggled unasked.
  assign proto_hit = (ack_sync != ack_prev) && ((state == IDLE) || (state == LAUNCH));

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      req_toggle  <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      xfer_count  <= 16'd0;
      ack_prev    <= 1'b0;
      tcnt        <= '0;
    end else begin
      ack_prev <= ack_sync;

      // data_out only moves on an accept edge, so it is stable for the
      // LAUNCH cycle before the toggle and for the whole wait.
      if (accept) begin
        data_out <= in_data;
        in_ready <= 1'b0;
      end else if ((state == IDLE) || done) begin
        in_ready <= 1'b1;
      end

      if (state == LAUNCH) begin
        req_toggle <= ~req_toggle;
        tcnt       <= '0;
      end else if (waiting && !tcnt_sat) begin
        tcnt <= tcnt + TCW'(1);
      end

      if (done) begin
        xfer_count <= xfer_count + 16'd1;
      end

      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end

      if (proto_hit) begin
        proto_err <= 1'b1;
      end else if (clr_err) begin
        proto_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcp_tx_ctrl.sv
module tb_mcp_tx_ctrl;

  logic        clk_tx = 1'b0;
  logic        clk_rx = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ack_toggle;
  logic        clr_err;
  logic        req_toggle;
  logic [7:0]  data_out;
  logic        busy;
  logic        timeout_err;
  logic        proto_err;
  logic [15:0] xfer_count;

  // ack source: 0 = loopback of req_toggle, 1 = RX-stage model, 2 = manual
  logic [1:0]  ack_mode;
  logic        ack_man;
  logic        ack_rx;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_tx = ~clk_tx;
  always #4 clk_rx = ~clk_rx;

  assign ack_toggle = (ack_mode == 2'd0) ? req_toggle :
                      (ack_mode == 2'd1) ? ack_rx : ack_man;

  mcp_tx_ctrl #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (10)
  ) dut (
    .clk_tx      (clk_tx),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ack_toggle  (ack_toggle),
    .clr_err     (clr_err),
    .req_toggle  (req_toggle),
    .data_out    (data_out),
    .busy        (busy),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .xfer_count  (xfer_count)
  );

  // RX stage model on an 8 ns clock: synchronise req, capture data on a
  // new request, answer with the matching ack level after RX_DLY cycles.
  localparam int RX_DLY = 50;
  logic       rx_s1, rx_s2, rx_seen;
  logic [7:0] rx_cap;
  int         rx_dly;

  always @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b0; rx_s2 <= 1'b0; rx_seen <= 1'b0;
      ack_rx <= 1'b0; rx_cap <= 8'h00; rx_dly <= 0;
    end else begin
      rx_s1 <= req_toggle;
      rx_s2 <= rx_s1;
      if (rx_s2 != rx_seen) begin
        rx_seen <= rx_s2;
        rx_cap  <= data_out;
        rx_dly  <= RX_DLY;
      end else if (rx_dly != 0) begin
        rx_dly <= rx_dly - 1;
        if (rx_dly == 1) ack_rx <= rx_seen;
      end
    end
  end

  // Transaction-level reference for loopback mode: an accepted word toggles
  // req one edge later and frees the block 2+SYNC_STAGES edges later.
  localparam int S = 2;
  int         cyc = 0;
  bit         model_on = 1'b0;
  logic       m_ready, m_busy, m_req;
  logic [7:0] m_data;
  logic [15:0] m_cnt;
  int         flip_at = -1;
  int         done_at = -1;

  task automatic model_edge();
    logic rb;
    rb = m_ready;
    if (cyc == flip_at) m_req = ~m_req;
    if (cyc == done_at) begin
      m_ready = 1'b1; m_busy = 1'b0; m_cnt = m_cnt + 16'd1;
    end
    if (in_valid && rb) begin
      m_data  = in_data;
      m_ready = 1'b0;
      m_busy  = 1'b1;
      flip_at = cyc + 1;
      done_at = cyc + 2 + S;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clk_tx cycle: inputs were set at the negedge, outputs are sampled
  // at the following negedge.
  task automatic step();
    @(posedge clk_tx);
    cyc++;
    if (model_on) model_edge();
    @(negedge clk_tx);
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_req"}, req_toggle, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_proto"}, proto_err, 0);
    chk({tag, "_cnt"}, xfer_count, 0);
  endtask

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        bsy;
    logic        req;
    logic [7:0]  dout;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] exp_cnt;

    // Back-to-back loopback of 0x11/0x22/0x33, one row per clk_tx edge.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 16'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
    tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
    tbl[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
    tbl[4]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 16'd1};
    tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 16'd1};
    tbl[6]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h22, 16'd1};
    tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h22, 16'd1};
    tbl[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h22, 16'd1};
    tbl[9]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h22, 16'd2};
    tbl[10] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h33, 16'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 16'd2};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 16'd2};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 16'd2};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 16'd3};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 16'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_err = 1'b0;
    ack_mode = 2'd0; ack_man = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_tx);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();
    chk("first_edge_in_ready", in_ready, 1);

    // Table-driven loopback
    for (int i = 0; i < 16; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
      step();
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_req", i), req_toggle, tbl[i].req);
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].dout);
      chk($sformatf("tbl%0d_cnt", i), xfer_count, tbl[i].cnt);
    end
    chk("tbl_tmo", timeout_err, 0);
    chk("tbl_proto", proto_err, 0);

    // Randomised loopback against the reference
    m_ready = 1'b1; m_busy = 1'b0; m_req = 1'b1; m_data = 8'h33; m_cnt = 16'd3;
    model_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      step();
      chk("rnd_in_ready", in_ready, m_ready);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_req", req_toggle, m_req);
      chk("rnd_data", data_out, m_data);
      chk("rnd_cnt", xfer_count, m_cnt);
    end
    in_valid = 1'b0;
    repeat (8) step();
    chk("rnd_drain_cnt", xfer_count, m_cnt);
    chk("rnd_proto", proto_err, 0);
    chk("rnd_tmo", timeout_err, 0);
    model_on = 1'b0;
    exp_cnt = m_cnt;

    // Hold check through the slow RX model
    repeat (70) step();
    ack_mode = 2'd1;
    in_valid = 1'b1; in_data = 8'h5C;
    step();
    chk("hold_accept_data", data_out, 8'h5C);
    chk("hold_accept_rdy", in_ready, 0);
    wait_ready(0, n);
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      step();
      n++;
      chk("hold_data", data_out, 8'h5C);
    end
    in_valid = 1'b0;
    chk("hold_wait_len", (n >= 40 && n < 200), 1);
    chk("hold_cnt", xfer_count, exp_cnt + 16'd1);
    chk("hold_rx_cap", rx_cap, 8'h5C);
    chk("hold_tmo_set", timeout_err, 1);
    exp_cnt = exp_cnt + 16'd1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("hold_tmo_clr", timeout_err, 0);

    // Timeout with ack stuck
    repeat (70) step();
    ack_man = ack_rx;
    ack_mode = 2'd2;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("tmo_not_yet", timeout_err, 0);
    step();
    chk("tmo_set", timeout_err, 1);
    chk("tmo_busy", busy, 1);
    repeat (15) step();
    chk("tmo_still_busy", busy, 1);
    chk("tmo_data_held", data_out, 8'hA5);
    chk("tmo_not_ready", in_ready, 0);
    ack_man = ~ack_man;
    wait_ready(10, n);
    chk("tmo_late_ack_rdy", in_ready, 1);
    chk("tmo_late_ack_cnt", xfer_count, exp_cnt + 16'd1);
    chk("tmo_late_ack_busy", busy, 0);
    chk("tmo_sticky", timeout_err, 1);
    exp_cnt = exp_cnt + 16'd1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("tmo_clr", timeout_err, 0);
    chk("tmo_no_proto", proto_err, 0);

    // Spurious ack while idle
    repeat (3) step();
    ack_man = ~ack_man;
    step();
    step();
    chk("proto_not_yet", proto_err, 0);
    step();
    chk("proto_set", proto_err, 1);
    ack_man = ~ack_man;
    step();
    step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("proto_set_wins", proto_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("proto_clr", proto_err, 0);

    // Reset mid-transfer
    in_valid = 1'b1; in_data = 8'h7E;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("mid_busy", busy, 1);
    chk("mid_data", data_out, 8'h7E);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    ack_man = 1'b0;
    ack_mode = 2'd0;
    @(negedge clk_tx);
    rst_n = 1'b1;
    step();
    chk("resume_rdy", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_valid = 1'b0;
    chk("resume_data", data_out, 8'h01);
    chk("resume_req0", req_toggle, 0);
    step();
    chk("resume_req1", req_toggle, 1);
    wait_ready(10, n);
    chk("resume_cnt", xfer_count, 16'd1);

    // Counter wrap
    force dut.xfer_count = 16'hFFFF;
    #1;
    release dut.xfer_count;
    @(negedge clk_tx);
    in_valid = 1'b1; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    wait_ready(10, n);
    chk("wrap_cnt", xfer_count, 16'h0000);
    chk("wrap_data", data_out, 8'h99);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mcp_tx_ctrl.md
Name: mcp_tx_ctrl

Overview:
- TX-domain front end of the toggle-based multi-cycle-path (MCP) CDC link.
- Accepts words from a local producer over a valid/ready handshake.
- Drives the held data bus and request toggle into the RX-domain synchroniser/capture stage.
- Throttles the producer until the RX side returns an acknowledge toggle, synchronised back into clk_tx, giving closed-loop MCP with no data loss or overwrite.

Parameters:
- DATA_W, 8: width of in_data / data_out.
- SYNC_STAGES, 2: flops in the ack_toggle synchroniser (legal 2..4).
- TIMEOUT_CYC, 255: clk_tx cycles in WAIT_ACK before timeout_err sets; 0 disables the timeout.

Ports:
- clk_tx  in  1  TX-domain clock.
- rst_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  Producer word valid.
- in_data  in  DATA_W  Producer word.
- in_ready  out  1  Block can accept a word (registered).
- ack_toggle  in  1  Acknowledge toggle from the RX domain; asynchronous to clk_tx.
- clr_err  in  1  Single-cycle pulse; clears the sticky error flags.
- req_toggle  out  1  Request toggle to the RX synchroniser (registered).
- data_out  out  DATA_W  Held MCP data to the RX capture register (registered).
- busy  out  1  High whenever state != IDLE.
- timeout_err  out  1  Sticky: ack not received within TIMEOUT_CYC.
- proto_err  out  1  Sticky: ack level changed while not in WAIT_ACK.
- xfer_count  out  16  Completed transfers; wraps 0xFFFF -> 0.

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk_tx.
- Reset values:
  - in_ready=0, req_toggle=0, data_out=0, busy=0, timeout_err=0, proto_err=0, xfer_count=0.
  - All ack synchroniser flops and ack_prev = 0; state=IDLE; timeout counter=0.
- in_ready rises on the first clk_tx edge after rst_n deasserts.
- Ack synchroniser: SYNC_STAGES flops on clk_tx; ack_sync is the last stage. No logic is permitted before the first flop.
- FSM states: IDLE, LAUNCH, WAIT_ACK.
  - IDLE: in_ready=1. At an edge with in_valid&&in_ready:
    - data_out <= in_data, in_ready <= 0, state <= LAUNCH.
    - If in_valid is low, the block holds.
  - LAUNCH (exactly 1 cycle): req_toggle <= ~req_toggle; timeout counter <= 0; state <= WAIT_ACK.
    - data_out is therefore stable for at least one clk_tx cycle before the toggle.
  - WAIT_ACK: completes when ack_sync == req_toggle (level compare, not edge). On that edge:
    - state <= IDLE, in_ready <= 1, xfer_count <= xfer_count+1.
- Otherwise in WAIT_ACK:
  - The timeout counter increments and saturates at TIMEOUT_CYC.
  - When the counter reaches TIMEOUT_CYC (and TIMEOUT_CYC != 0), timeout_err <= 1.
  - The state stays WAIT_ACK with data held. There is no retry and no abort; a late ack still completes normally.
- Hold rule: data_out changes only on an accept edge. It never changes in LAUNCH or WAIT_ACK.
- Loopback latency (ack_toggle tied to req_toggle), with accept at edge N:
  - N+1: req toggles.
  - N+1+SYNC_STAGES: ack_sync matches.
  - N+2+SYNC_STAGES: in_ready=1.
  - N+3+SYNC_STAGES: next accept at the earliest. With SYNC_STAGES=2 this is one word per 5 cycles.
- proto_err: set when ack_sync != ack_prev (ack_prev = ack_sync delayed one cycle) while state is IDLE or LAUNCH.
- Error clear: clr_err clears timeout_err and proto_err. If a set condition and clr_err occur in the same cycle, set wins.
- Reset mid-transfer: all state returns to reset values immediately; the in-flight word is dropped. The RX domain is reset by the same rst_n, so toggle parity stays consistent.
- in_valid deasserting while in_ready=0 is permitted and has no effect. in_data is sampled only on the accept edge.

Test Plan:
- Reset/loopback:
  - Stimulus: release reset; ack_toggle looped to req_toggle; push 0x11, 0x22, 0x33 back-to-back with in_valid held high.
  - Response: accepts 5 cycles apart; data_out = 0x11/0x22/0x33; req_toggle goes 1,0,1; xfer_count=3; no errors.
- Hold check:
  - Stimulus: ack delayed 40 cycles via a model of the RX stage at 8ns clk_rx; producer changes in_data every cycle.
  - Response: data_out stays at the accepted value until in_ready returns; in_ready stays 0 throughout the wait.
- Timeout:
  - Stimulus: TIMEOUT_CYC=10, ack_toggle stuck at 0, push 0xA5.
  - Response: timeout_err=1 ten cycles after entering WAIT_ACK; busy stays 1.
  - Then: toggle ack. Response: completes, xfer_count+1.
  - Then: clr_err pulse. Response: timeout_err=0.
- Protocol error:
  - Stimulus: toggle ack_toggle while IDLE.
  - Response: proto_err=1 after SYNC_STAGES+1 cycles.
  - Then: clr_err in the same cycle as a second spurious toggle's detection. Response: proto_err stays 1.
- Reset mid-operation:
  - Stimulus: assert rst_n during WAIT_ACK carrying 0x7E.
  - Response: all outputs at reset values immediately.
  - Then: resume. Response: next word 0x01 transfers with req_toggle 0->1.
- Counter wrap:
  - Stimulus: force xfer_count=0xFFFF, complete one transfer.
  - Response: xfer_count=0x0000.
